// File: rtl/danger_spawner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | danger_spawner_if                                                          |
// | Bundle between the game controller and the obstacle spawner.               |
// |   game_clk          slow game clock; a step is taken on each rising edge   |
// |   game_state[1:0]   00 idle/restart, 01 running, 10/11 game over           |
// |   danger_posN[9:0]  x-position of obstacle slot N                          |
// |   danger_typeN[2:0] obstacle type of slot N (0..4)                         |
// |   danger_enN        slot N is active and drawn                             |
// | master: game-side driver of game_clk/game_state, reader of the slots.      |
// | slave : the spawner itself.                                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface danger_spawner_if;
  logic       game_clk;
  logic [1:0] game_state;
  logic [9:0] danger_pos1;
  logic [9:0] danger_pos2;
  logic [9:0] danger_pos3;
  logic [2:0] danger_type1;
  logic [2:0] danger_type2;
  logic [2:0] danger_type3;
  logic       danger_en1;
  logic       danger_en2;
  logic       danger_en3;

  modport master (
    output game_clk, game_state,
    input  danger_pos1, danger_pos2, danger_pos3,
    input  danger_type1, danger_type2, danger_type3,
    input  danger_en1, danger_en2, danger_en3
  );

  modport slave (
    input  game_clk, game_state,
    output danger_pos1, danger_pos2, danger_pos3,
    output danger_type1, danger_type2, danger_type3,
    output danger_en1, danger_en2, danger_en3
  );
endinterface
`default_nettype wire

// File: rtl/danger_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | danger_spawner                                                             |
// | Maintains three obstacle slots (position, type, enable). On each rising    |
// | edge of game_clk while running, active slots move left by SPEED and a new  |
// | obstacle may spawn at the right edge, gated by a 16-bit Galois LFSR and a  |
// | minimum travelled distance since the previous spawn.                       |
// | Ports:                                                                     |
// |   clk     system clock                                                     |
// |   rst     synchronous reset, active low                                    |
// |   bus_io  danger_spawner_if.slave (game_clk, game_state in; slots out)     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module danger_spawner #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned MIN_GAP   = 160,
  parameter logic [1:0]  PROB_MASK = 2'b11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input wire              clk,
  input wire              rst,
  danger_spawner_if.slave bus_io
);

  localparam logic [1:0]  ST_IDLE = 2'b00;
  localparam logic [1:0]  ST_RUN  = 2'b01;

  // Gap counter only has to hold MIN_GAP + SPEED before saturation.
  localparam int          GAP_W     = $clog2(MIN_GAP + SPEED + 1) + 1;
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_SPEED = GAP_W'(SPEED);
  localparam logic [9:0]  SPEED_V   = 10'(SPEED);
  localparam logic [9:0]  SCREEN_V  = 10'(SCREEN_W);
  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0][9:0]  pos_q, pos_d;
  logic [2:0][2:0]  type_q, type_d;
  logic [2:0]       en_q, en_d;

  logic             tick;
  logic             spawn;
  logic [1:0]       free_idx;
  logic [GAP_W-1:0] gap_sum;
  logic [2:0]       type_raw;
  logic [2:0]       type_new;

  assign tick = s1_q & ~s2_q;

  always_comb begin
    s1_d     = bus_io.game_clk;
    s2_d     = s1_q;
    lfsr_d   = lfsr_q;
    gap_d    = gap_q;
    pos_d    = pos_q;
    type_d   = type_q;
    en_d     = en_q;

    // Lowest-index free slot, judged on pre-step enables so a slot freed
    // by this step's move is not reused until the next step.
    free_idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (!en_q[i]) begin
        free_idx = 2'(i);
      end
    end

    spawn    = (gap_q >= GAP_MAX) &&
               ((lfsr_q[1:0] & PROB_MASK) == 2'b00) &&
               (en_q != 3'b111);
    gap_sum  = gap_q + GAP_SPEED;
    type_raw = lfsr_q[6:4];
    type_new = (type_raw >= 3'd5) ? (type_raw - 3'd5) : type_raw;

    case (bus_io.game_state)
      ST_IDLE: begin
        en_d   = '0;
        pos_d  = '0;
        type_d = '0;
        gap_d  = GAP_MAX;
      end
      ST_RUN: begin
        if (tick) begin
          for (int i = 0; i < 3; i++) begin
            if (en_q[i]) begin
              if (pos_q[i] <= SPEED_V) begin
                en_d[i]  = 1'b0;
                pos_d[i] = 10'd0;
              end else begin
                pos_d[i] = pos_q[i] - SPEED_V;
              end
            end
          end

          gap_d = (gap_sum > GAP_MAX) ? GAP_MAX : gap_sum;

          // The chosen slot was idle pre-step, so the move above never
          // touched it and the spawn position is not stepped this time.
          if (spawn) begin
            en_d[free_idx]   = 1'b1;
            pos_d[free_idx]  = SCREEN_V;
            type_d[free_idx] = type_new;
            gap_d            = '0;
          end

          lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
      end
      default: begin
        // Game over: everything holds.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lfsr_q <= SEED_EFF;
      gap_q  <= GAP_MAX;
      pos_q  <= '0;
      type_q <= '0;
      en_q   <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lfsr_q <= lfsr_d;
      gap_q  <= gap_d;
      pos_q  <= pos_d;
      type_q <= type_d;
      en_q   <= en_d;
    end
  end

  assign bus_io.danger_pos1  = pos_q[0];
  assign bus_io.danger_pos2  = pos_q[1];
  assign bus_io.danger_pos3  = pos_q[2];
  assign bus_io.danger_type1 = type_q[0];
  assign bus_io.danger_type2 = type_q[1];
  assign bus_io.danger_type3 = type_q[2];
  assign bus_io.danger_en1   = en_q[0];
  assign bus_io.danger_en2   = en_q[1];
  assign bus_io.danger_en3   = en_q[2];

endmodule
`default_nettype wire

// File: tb/tb_danger_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_danger_spawner                                                          |
// | Two spawners share one stimulus: dut_a with PROB_MASK = 0 (spawns whenever |
// | the gap allows) and dut_b with the default mask 2'b11. Both are checked    |
// | after every step against a step-level model; dut_a is additionally checked |
// | against hand-computed slot positions.                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_danger_spawner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  danger_spawner_if if_a ();
  danger_spawner_if if_b ();

  danger_spawner #(.PROB_MASK(2'b00)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if_a.slave)
  );

  danger_spawner dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if_b.slave)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_steps = 0;

  // ---------------- step-level model, index 0 = dut_a, 1 = dut_b -----------
  int          m_pos  [2][3];
  int          m_typ  [2][3];
  bit          m_en   [2][3];
  logic [15:0] m_lfsr [2];
  int          m_gap  [2];
  logic [1:0]  m_mask [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear(input int m);
    for (int i = 0; i < 3; i++) begin
      m_pos[m][i] = 0;
      m_typ[m][i] = 0;
      m_en[m][i]  = 1'b0;
    end
    m_gap[m] = 160;
  endtask

  task automatic model_step(input int m);
    bit en_pre [3];
    int g;
    int idx;
    int t;
    for (int i = 0; i < 3; i++) en_pre[i] = m_en[m][i];
    for (int i = 0; i < 3; i++) begin
      if (en_pre[i]) begin
        if (m_pos[m][i] <= 4) begin
          m_en[m][i]  = 1'b0;
          m_pos[m][i] = 0;
        end else begin
          m_pos[m][i] = m_pos[m][i] - 4;
        end
      end
    end
    g = m_gap[m] + 4;
    if (g > 160) g = 160;
    if (m_gap[m] >= 160 && (m_lfsr[m][1:0] & m_mask[m]) == 2'b00 &&
        !(en_pre[0] && en_pre[1] && en_pre[2])) begin
      idx = !en_pre[0] ? 0 : (!en_pre[1] ? 1 : 2);
      t = int'(m_lfsr[m][6:4]);
      if (t >= 5) t = t - 5;
      m_en[m][idx]  = 1'b1;
      m_pos[m][idx] = 640;
      m_typ[m][idx] = t;
      g = 0;
    end
    m_gap[m]  = g;
    m_lfsr[m] = {1'b0, m_lfsr[m][15:1]} ^ (m_lfsr[m][0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic cmp_model(input int m, input string tag);
    logic [9:0] p [3];
    logic [2:0] t [3];
    logic       e [3];
    if (m == 0) begin
      p[0] = if_a.danger_pos1;  p[1] = if_a.danger_pos2;  p[2] = if_a.danger_pos3;
      t[0] = if_a.danger_type1; t[1] = if_a.danger_type2; t[2] = if_a.danger_type3;
      e[0] = if_a.danger_en1;   e[1] = if_a.danger_en2;   e[2] = if_a.danger_en3;
    end else begin
      p[0] = if_b.danger_pos1;  p[1] = if_b.danger_pos2;  p[2] = if_b.danger_pos3;
      t[0] = if_b.danger_type1; t[1] = if_b.danger_type2; t[2] = if_b.danger_type3;
      e[0] = if_b.danger_en1;   e[1] = if_b.danger_en2;   e[2] = if_b.danger_en3;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s step%0d pos%0d", tag, n_steps, i + 1), 32'(p[i]), 32'(m_pos[m][i]));
      chk($sformatf("%s step%0d type%0d", tag, n_steps, i + 1), 32'(t[i]), 32'(m_typ[m][i]));
      chk($sformatf("%s step%0d en%0d", tag, n_steps, i + 1), 32'(e[i]), 32'(m_en[m][i]));
    end
  endtask

  task automatic set_gclk(input logic v);
    if_a.game_clk = v;
    if_b.game_clk = v;
  endtask

  task automatic set_state(input logic [1:0] s);
    if_a.game_state = s;
    if_b.game_state = s;
  endtask

  // One clean game_clk pulse: 2 clk cycles high, 2 low. Returns at a negedge.
  task automatic gpulse();
    set_gclk(1'b1);
    repeat (2) @(negedge clk);
    set_gclk(1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_step();
    gpulse();
    model_step(0);
    model_step(1);
    n_steps++;
    cmp_model(0, "A");
    cmp_model(1, "B");
  endtask

  // ---------------- hand-computed dut_a slot table -------------------------
  // Slot 1 spawns on step 1. The gap reaches 160 after 40 more steps, so the
  // next spawn is 41 steps later: slot 2 on step 42, slot 3 on step 83.
  // Slot 1 expires on step 161 (no spawn, it was full pre-step) and is
  // refilled on step 162. t1 = -1 means type is not checked.
  typedef struct {
    int step;
    int p1; int p2; int p3;
    bit e1; bit e2; bit e3;
    int t1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    m_mask[0] = 2'b00;
    m_mask[1] = 2'b11;

    tbl[0]  = '{step:1,   p1:640, p2:0,   p3:0,   e1:1, e2:0, e3:0, t1:1};
    tbl[1]  = '{step:2,   p1:636, p2:0,   p3:0,   e1:1, e2:0, e3:0, t1:1};
    tbl[2]  = '{step:41,  p1:480, p2:0,   p3:0,   e1:1, e2:0, e3:0, t1:-1};
    tbl[3]  = '{step:42,  p1:476, p2:640, p3:0,   e1:1, e2:1, e3:0, t1:-1};
    tbl[4]  = '{step:43,  p1:472, p2:636, p3:0,   e1:1, e2:1, e3:0, t1:-1};
    tbl[5]  = '{step:82,  p1:316, p2:480, p3:0,   e1:1, e2:1, e3:0, t1:-1};
    tbl[6]  = '{step:83,  p1:312, p2:476, p3:640, e1:1, e2:1, e3:1, t1:-1};
    tbl[7]  = '{step:124, p1:148, p2:312, p3:476, e1:1, e2:1, e3:1, t1:-1};
    tbl[8]  = '{step:160, p1:4,   p2:168, p3:332, e1:1, e2:1, e3:1, t1:-1};
    tbl[9]  = '{step:161, p1:0,   p2:164, p3:328, e1:0, e2:1, e3:1, t1:-1};
    tbl[10] = '{step:162, p1:640, p2:160, p3:324, e1:1, e2:1, e3:1, t1:-1};
    tbl[11] = '{step:163, p1:636, p2:156, p3:320, e1:1, e2:1, e3:1, t1:-1};

    // ---- reset, with game_clk toggling underneath ----
    set_state(2'b01);
    set_gclk(1'b0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_gclk(c[0] ? 1'b0 : 1'b1);
    end
    set_gclk(1'b0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      model_clear(m);
      m_lfsr[m] = 16'hACE1;
    end
    cmp_model(0, "reset A");
    cmp_model(1, "reset B");
    rst = 1'b1;
    @(negedge clk);

    // ---- table-driven movement / expiry / refill ----
    for (int k = 0; k < 12; k++) begin
      while (n_steps < tbl[k].step) run_step();
      chk($sformatf("tbl step%0d pos1", tbl[k].step), 32'(if_a.danger_pos1), 32'(tbl[k].p1));
      chk($sformatf("tbl step%0d pos2", tbl[k].step), 32'(if_a.danger_pos2), 32'(tbl[k].p2));
      chk($sformatf("tbl step%0d pos3", tbl[k].step), 32'(if_a.danger_pos3), 32'(tbl[k].p3));
      chk($sformatf("tbl step%0d en1", tbl[k].step), 32'(if_a.danger_en1), 32'(tbl[k].e1));
      chk($sformatf("tbl step%0d en2", tbl[k].step), 32'(if_a.danger_en2), 32'(tbl[k].e2));
      chk($sformatf("tbl step%0d en3", tbl[k].step), 32'(if_a.danger_en3), 32'(tbl[k].e3));
      if (tbl[k].t1 >= 0)
        chk($sformatf("tbl step%0d type1", tbl[k].step), 32'(if_a.danger_type1), 32'(tbl[k].t1));
    end

    // ---- freeze for 20 game_clk edges, then resume ----
    set_state(2'b10);
    repeat (20) gpulse();
    cmp_model(0, "freeze A");
    cmp_model(1, "freeze B");
    chk("freeze pos2", 32'(if_a.danger_pos2), 32'd156);
    set_state(2'b01);
    run_step();
    chk("resume pos1", 32'(if_a.danger_pos1), 32'd632);
    chk("resume pos2", 32'(if_a.danger_pos2), 32'd152);

    // ---- idle for one cycle clears everything, immediate spawn after ----
    set_state(2'b00);
    @(negedge clk);
    set_state(2'b01);
    model_clear(0);
    model_clear(1);
    cmp_model(0, "idle A");
    cmp_model(1, "idle B");
    run_step();
    chk("post-idle en1", 32'(if_a.danger_en1), 32'd1);
    chk("post-idle pos1", 32'(if_a.danger_pos1), 32'd640);
    chk("post-idle en2", 32'(if_a.danger_en2), 32'd0);

    // ---- step timing: move appears at the 2nd edge after the rise ----
    set_gclk(1'b1);
    @(negedge clk);
    chk("timing E0 pos1", 32'(if_a.danger_pos1), 32'd640);
    @(negedge clk);
    model_step(0);
    model_step(1);
    n_steps++;
    chk("timing E1 pos1", 32'(if_a.danger_pos1), 32'd636);
    set_gclk(1'b0);
    repeat (2) @(negedge clk);
    cmp_model(0, "timing A");
    cmp_model(1, "timing B");

    // game_clk held high for 50 cycles still gives a single move
    set_gclk(1'b1);
    repeat (50) @(negedge clk);
    set_gclk(1'b0);
    repeat (2) @(negedge clk);
    model_step(0);
    model_step(1);
    n_steps++;
    chk("long-high pos1", 32'(if_a.danger_pos1), 32'd632);
    cmp_model(0, "long-high A");
    cmp_model(1, "long-high B");

    // ---- LFSR-gated spawning over 500 steps ----
    for (int s = 0; s < 500; s++) begin
      run_step();
      chk($sformatf("B type range step%0d", n_steps),
          32'((if_b.danger_type1 <= 3'd4) && (if_b.danger_type2 <= 3'd4) &&
              (if_b.danger_type3 <= 3'd4)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
